// File: rtl/ex_stage_pipe.sv
// Registered MIPS EX stage: ALU, branch target and destination in 1 cycle; mult takes DATA_W+1 cycles.
// Backpressure: in_ready drops while the EX/MEM slot is held unconsumed, a mult is in flight, or on flush.
module ex_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_dst,
  input  logic              alu_src,
  input  logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] sign_ext,
  input  logic [REG_AW-1:0] inst_rt,
  input  logic [REG_AW-1:0] inst_rd,
  input  logic [4:0]        ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] add_result,
  output logic [DATA_W-1:0] read_data2_out,
  output logic              zero_out,
  output logic [REG_AW-1:0] write_reg,
  output logic [4:0]        ctrl_out,
  output logic              busy
);
  typedef enum logic [1:0] {RUN, MUL, DONE} state_t;
  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MULT = 6'b011000;

  typedef struct packed {
    logic [DATA_W-1:0] add_result;
    logic [DATA_W-1:0] read_data2;
    logic [REG_AW-1:0] write_reg;
    logic [4:0]        ctrl;
  } side_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  side_t             side;
  side_t             side_nxt;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_comb;
  logic [5:0]        funct;
  logic              is_mult;
  logic              accept;

  assign funct    = sign_ext[5:0];
  assign op_b     = alu_src ? sign_ext : read_data2;
  assign is_mult  = (alu_op == 2'b10) && (funct == F_MULT);
  assign in_ready = !flush && (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MUL);

  always_comb begin
    side_nxt            = '0;
    side_nxt.add_result = pc_plus4 + (sign_ext << 2);
    side_nxt.read_data2 = read_data2;
    side_nxt.write_reg  = reg_dst ? inst_rd : inst_rt;
    side_nxt.ctrl       = ctrl_in;
  end

  // mult never uses this path; its product comes from the shift-add accumulator
  always_comb begin
    alu_comb = '0;
    case (alu_op)
      2'b01: alu_comb = read_data1 - op_b;
      2'b10: begin
        case (funct)
          F_ADD:   alu_comb = read_data1 + op_b;
          F_SUB:   alu_comb = read_data1 - op_b;
          F_AND:   alu_comb = read_data1 & op_b;
          F_OR:    alu_comb = read_data1 | op_b;
          F_SLT:   alu_comb = {{(DATA_W-1){1'b0}}, ($signed(read_data1) < $signed(op_b))};
          default: alu_comb = '0;
        endcase
      end
      default: alu_comb = read_data1 + op_b;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      count          <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      side           <= '0;
      out_valid      <= 1'b0;
      alu_result     <= '0;
      add_result     <= '0;
      read_data2_out <= '0;
      zero_out       <= 1'b0;
      write_reg      <= '0;
      ctrl_out       <= '0;
    end else if (flush) begin
      state     <= RUN;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      case (state)
        RUN: begin
          if (accept && is_mult) begin
            mcand  <= read_data1;
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
            side   <= side_nxt;
            state  <= MUL;
          end else if (accept) begin
            out_valid      <= 1'b1;
            alu_result     <= alu_comb;
            zero_out       <= (alu_comb == '0);
            add_result     <= side_nxt.add_result;
            read_data2_out <= side_nxt.read_data2;
            write_reg      <= side_nxt.write_reg;
            ctrl_out       <= side_nxt.ctrl;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == CNT_W'(DATA_W - 1)) state <= DONE;
        end
        DONE: begin
          if (!out_valid || out_ready) begin
            out_valid      <= 1'b1;
            alu_result     <= acc;
            zero_out       <= (acc == '0);
            add_result     <= side.add_result;
            read_data2_out <= side.read_data2;
            write_reg      <= side.write_reg;
            ctrl_out       <= side.ctrl;
            state          <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: directed cases plus randomized traffic against a behavioural model.
module tb_ex_stage_pipe;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          reg_dst = 1'b0;
  logic          alu_src = 1'b0;
  logic [1:0]    alu_op = 2'b00;
  logic [DW-1:0] pc_plus4 = '0;
  logic [DW-1:0] read_data1 = '0;
  logic [DW-1:0] read_data2 = '0;
  logic [DW-1:0] sign_ext = '0;
  logic [AW-1:0] inst_rt = '0;
  logic [AW-1:0] inst_rd = '0;
  logic [4:0]    ctrl_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] add_result;
  logic [DW-1:0] read_data2_out;
  logic          zero_out;
  logic [AW-1:0] write_reg;
  logic [4:0]    ctrl_out;
  logic          busy;

  ex_stage_pipe #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
    .pc_plus4(pc_plus4), .read_data1(read_data1), .read_data2(read_data2), .sign_ext(sign_ext),
    .inst_rt(inst_rt), .inst_rd(inst_rd), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .add_result(add_result), .read_data2_out(read_data2_out),
    .zero_out(zero_out), .write_reg(write_reg), .ctrl_out(ctrl_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] add;
    logic [DW-1:0] rd2;
    logic          zero;
    logic [AW-1:0] wr;
    logic [4:0]    ctrl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: what the instruction means, not how the stage computes it.
  function automatic exp_t model();
    exp_t          e;
    logic [DW-1:0] a, b, r;
    a = read_data1;
    b = alu_src ? sign_ext : read_data2;
    if (alu_op == 2'b01) r = a - b;
    else if (alu_op == 2'b10) begin
      case (sign_ext[5:0])
        6'h20:   r = a + b;
        6'h22:   r = a - b;
        6'h24:   r = a & b;
        6'h25:   r = a | b;
        6'h2a:   r = (int'(a) < int'(b)) ? 1 : 0;
        6'h18:   r = DW'(longint'(a) * longint'(b));
        default: r = 0;
      endcase
    end else r = a + b;
    e.alu  = r;
    e.zero = (r == 0);
    e.add  = pc_plus4 + sign_ext * 4;
    e.rd2  = read_data2;
    e.wr   = reg_dst ? inst_rd : inst_rt;
    e.ctrl = ctrl_in;
    return e;
  endfunction

  // Monitor: every MEM-side handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got alu 0x%0h, expected no output", alu_result);
      end else begin
        mon_e = sb.pop_front();
        chk("alu_result", 64'(alu_result), 64'(mon_e.alu));
        chk("zero_out", 64'(zero_out), 64'(mon_e.zero));
        chk("add_result", 64'(add_result), 64'(mon_e.add));
        chk("read_data2_out", 64'(read_data2_out), 64'(mon_e.rd2));
        chk("write_reg", 64'(write_reg), 64'(mon_e.wr));
        chk("ctrl_out", 64'(ctrl_out), 64'(mon_e.ctrl));
      end
    end
  end

  // One clock: record acceptance/flush at the negedge, then advance past the next rising edge.
  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready) sb.push_back(model());
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] se, input logic src);
    in_valid   = 1'b1;
    alu_op     = op;
    read_data1 = a;
    read_data2 = b;
    sign_ext   = se;
    alu_src    = src;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_alu_result"}, 64'(alu_result), 64'd0);
    chk({tag, "_add_result"}, 64'(add_result), 64'd0);
    chk({tag, "_read_data2_out"}, 64'(read_data2_out), 64'd0);
    chk({tag, "_zero_wr_ctrl"}, 64'({zero_out, write_reg, ctrl_out}), 64'd0);
  endtask

  int            cnt;
  int            bad;
  logic [DW-1:0] held;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    chk("out_valid_after_reset", 64'(out_valid), 64'd0);

    // back-to-back single-cycle ops with MEM always ready
    out_ready = 1'b1;
    pc_plus4  = 32'h100;
    drive(2'b10, 32'd7, 32'd5, 32'h20, 1'b0);
    step();
    chk("add_7_5", 64'(alu_result), 64'd12);
    drive(2'b10, 32'd5, 32'd5, 32'h22, 1'b0);
    step();
    chk("sub_zero_flag", 64'({out_valid, zero_out}), 64'b11);
    drive(2'b10, 32'hFFFF_FFFF, 32'd1, 32'h2a, 1'b0);
    step();
    chk("slt_neg", 64'(alu_result), 64'd1);
    drive(2'b00, 32'd0, 32'd0, 32'd3, 1'b1);
    step();
    chk("branch_target", 64'(add_result), 64'h10C);

    // destination select and control passthrough
    inst_rt = 5'd8;
    inst_rd = 5'd17;
    ctrl_in = 5'b10110;
    reg_dst = 1'b0;
    step();
    chk("write_reg_rt", 64'(write_reg), 64'd8);
    reg_dst = 1'b1;
    step();
    chk("write_reg_rd", 64'({write_reg, ctrl_out}), 64'({5'd17, 5'b10110}));

    // mult latency: result exactly DW+1 cycles after accept
    drive(2'b10, 32'hFFFF_FFFF, 32'd3, 32'h18, 1'b0);
    step();
    in_valid = 1'b0;
    bad = 0;
    cnt = busy ? 1 : 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (out_valid) begin
        chk("mult_latency", 64'(i), 64'(DW + 1));
        break;
      end
      if (in_ready) bad++;
      if (busy) cnt++;
      if (i == 100) chk("mult_timeout", 64'd0, 64'd1);
    end
    chk("mult_result", 64'(alu_result), 64'hFFFF_FFFD);
    chk("mult_in_ready_low", 64'(bad), 64'd0);
    chk("mult_busy_cycles", 64'(cnt), 64'(DW));

    // backpressure: held result stays put and input is blocked
    out_ready = 1'b0;
    drive(2'b01, 32'd100, 32'd1, 32'd0, 1'b0);
    step();
    held = alu_result;
    drive(2'b00, 32'd1, 32'd2, 32'd0, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (in_ready || !out_valid || alu_result !== held) bad++;
    end
    chk("backpressure_hold", 64'(bad), 64'd0);
    out_ready = 1'b1;
    step();
    // mult completing while MEM stalls: one result, held until consumed
    drive(2'b10, 32'd1234, 32'd5678, 32'h18, 1'b0);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (DW + 5) step();
    chk("mult_held_valid", 64'({out_valid, alu_result}), 64'({1'b1, 32'd7006652}));
    out_ready = 1'b1;
    step();
    chk("mult_no_duplicate", 64'(out_valid), 64'd0);

    // flush at mult step 10, coincident with a valid instruction
    drive(2'b10, 32'd9, 32'd9, 32'h18, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(2'b10, 32'd20, 32'd22, 32'h20, 1'b0);
    #1;
    chk("flush_blocks_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("flush_squash", 64'({out_valid, busy}), 64'd0);
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    chk("add_after_flush", 64'({out_valid, alu_result}), 64'({1'b1, 32'd42}));
    in_valid = 1'b0;
    step();

    // asynchronous reset in the middle of a mult discards it
    drive(2'b10, 32'd3, 32'd3, 32'h18, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("midmult_reset");
    sb.delete();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (DW + 4) step();
    chk("no_output_after_reset", 64'(out_valid), 64'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [5:0] functs [8];
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h18, 6'h00, 6'h3f};
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 59) == 0);
      if (flush) out_ready = 1'b0;
      alu_op     = 2'($urandom_range(0, 3));
      alu_src    = 1'($urandom_range(0, 1));
      reg_dst    = 1'($urandom_range(0, 1));
      read_data1 = $urandom();
      read_data2 = ($urandom_range(0, 7) == 0) ? read_data1 : $urandom();
      sign_ext   = $urandom();
      if (alu_op == 2'b10) sign_ext[5:0] = functs[$urandom_range(0, 7)];
      pc_plus4   = $urandom();
      inst_rt    = 5'($urandom());
      inst_rd    = 5'($urandom());
      ctrl_in    = 5'($urandom());
      step();
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) step();
    step();
    chk("drain_scoreboard", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised, registered execution stage for the pipelined MIPS core. It replaces the purely combinational EX logic with an EX/MEM output register, a valid/ready handshake on both sides, and a multi-cycle `mult` that stalls the upstream ID/EX stage. It sits between the ID/EX pipeline register and the MEM stage. It computes:
- the ALU result and zero flag;
- the branch target (PC+4 + imm<<2);
- the destination register selection.

It also forwards the MEM/WB control bits.

## Interface
- `DATA_W`, 32: datapath width (≥8); ALU, immediate, PC and data widths.
- `REG_AW`, 5: register-address width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous squash of output register and any in-progress mult.
- `in_valid`  in  1  ID/EX presents an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `reg_dst`, `alu_src`  in  1 each  destination select (1 = rd) and ALU-B select (1 = immediate).
- `alu_op`  in  2  00 add, 01 sub, 10 R-type by funct, 11 treated as 00.
- `pc_plus4`, `read_data1`, `read_data2`, `sign_ext`  in  `DATA_W` each  operands; funct = `sign_ext[5:0]`.
- `inst_rt`, `inst_rd`  in  `REG_AW` each  candidate destination registers.
- `ctrl_in`  in  5  {MemtoReg, RegWrite, MemRead, MemWrite, Branch}.
- `out_valid`  out  1  EX/MEM register holds a valid result.
- `out_ready`  in  1  MEM consumes the result this cycle.
- `alu_result`, `add_result`, `read_data2_out`  out  `DATA_W` each  registered results.
- `zero_out`  out  1  registered `alu_result == 0`.
- `write_reg`  out  `REG_AW`  registered destination register.
- `ctrl_out`  out  5  registered `ctrl_in`.
- `busy`  out  1  multiplier iterating.

## Operation
- **R-type funct codes:**
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt (signed compare, result 0/1)
  - 011000 mult, which returns the low `DATA_W` bits of the product (identical for signed and unsigned operands)
  - any other funct: result 0
- **Arithmetic:** wraps mod 2^`DATA_W`; no overflow trap.
- **Operands:** B = `alu_src` ? `sign_ext` : `read_data2`.
- **Branch target:** `add_result` = `pc_plus4` + (`sign_ext` << 2), truncated to `DATA_W`.
- **Destination:** `write_reg` = `reg_dst` ? `inst_rd` : `inst_rt`.
- **FSM states:**
  - **RUN:** `in_ready` = !`out_valid` || `out_ready`. Acceptance is `in_valid` && `in_ready`.
    - Non-mult instruction: all outputs load on that edge and `out_valid` ← 1.
    - Mult: operands, `add_result`, `write_reg`, `ctrl`, `read_data2` are latched into a side buffer; counter ← 0; go to MUL.
    - No acceptance and `out_ready`: `out_valid` ← 0.
  - **MUL:** `in_ready` = 0, `busy` = 1.
    - Each cycle one shift-add step: if multiplier bit 0 is set, acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1.
    - After `DATA_W` steps, go to DONE.
    - `out_ready` may still drain a previously held result (`out_valid` ← 0).
  - **DONE:** `in_ready` = 0, `busy` = 0. When `out_valid` = 0 or `out_ready` = 1: load acc and side buffer into the output register, `out_valid` ← 1, return to RUN. Otherwise hold.
- **`flush`:** overrides everything: `out_valid` ← 0, state ← RUN, counter cleared, no acceptance that cycle (`in_ready` = 0 while `flush` = 1).
- **Data hold:** output data fields hold their value while `out_valid` && !`out_ready`. They are don't-care when `out_valid` = 0 but must not be X after reset.

## Timing
- **Reset (async assert, sync release):** state RUN, `out_valid` 0, `busy` 0, all data outputs 0, `ctrl_out` 0, `write_reg` 0, `zero_out` 0, `in_ready` 1 on the first cycle after release.
- **Single-cycle ops:** latency 1. Accepted at edge N → visible after edge N. Full throughput: one instruction per cycle when `out_ready` = 1.
- **Mult:** accepted at edge N, steps on edges N+1…N+`DATA_W`, DONE after N+`DATA_W`, result loads on edge N+`DATA_W`+1 if the slot is free. Minimum latency `DATA_W`+1 cycles.
- **Simultaneous consume and accept:** `out_ready` with acceptance in the same cycle → output register overwritten, `out_valid` stays 1 (no bubble).
- **Reset mid-mult:** result discarded, no output produced.
- **Combinational paths:** `in_ready` depends combinationally only on state, `out_valid`, `out_ready`, `flush`.

## Test plan
- **Reset:** `reset_n` low mid-cycle → all outputs 0 immediately; after release `in_ready` = 1, `out_valid` = 0.
- **Back-to-back single-cycle ops:** add 7+5, sub 5−5, slt −1<1 (`DATA_W`=32), `out_ready` = 1 → one result per cycle: 12/`zero` 0, 0/`zero` 1, 1. Branch target: `pc_plus4` = 0x100, imm = 3 → `add_result` 0x10C.
- **Mult:** 0xFFFFFFFF × 3 → `alu_result` 0xFFFFFFFD exactly 33 cycles after accept; `in_ready` low for cycles 1–33.
- **Backpressure:** hold `out_ready` = 0 with `out_valid` = 1 → `in_ready` = 0 and outputs stable for 10 cycles. Then a mult finishing into a full slot waits in DONE until `out_ready`, with no result lost or duplicated.
- **Flush:** `flush` at step 10 of a mult → `out_valid` 0, `busy` 0 next cycle; the next add is accepted and completes normally. Also: `flush` coincident with `in_valid` → instruction not accepted.
- **Destination/control passthrough:** `reg_dst` 0/1 with rt = 8, rd = 17 → `write_reg` 8/17. `ctrl_in` 5'b10110 → appears on `ctrl_out` aligned with its result.
